rr_grant_consumer: RTL and testbench

//  Requester-side companion to the TX round-robin arbiter. Buffers descriptors from N per-queue

---
 rtl/rr_grant_consumer_pkg.sv | 26 ++
 rtl/rr_grant_consumer_sync_fifo.sv | 46 ++++
 rtl/rr_grant_consumer.sv | 110 +++++++++++
 tb/tb_rr_grant_consumer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_consumer_pkg.sv
// Shared helpers for the round-robin grant consumer.
// Width math, one-hot checks and the client-id type.
package rr_grant_consumer_pkg;

    localparam int ID_MAX = 8;

    typedef logic [ID_MAX-1:0] cid_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic onehot0(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction

    function automatic logic onehot(input logic [31:0] v);
        return (v != 32'd0) && onehot0(v);
    endfunction

endpackage

// File: rtl/rr_grant_consumer_sync_fifo.sv
// Small synchronous FIFO with async active-low reset and occupancy count.
// Caller guarantees no push when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_an,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    assign rdata = mem[rptr];

    // Storage is cleared on reset so the output head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/rr_grant_consumer.sv
// Requester side of the TX round-robin arbiter: per-client FIFOs,
// request/credit generation, grant decode and a 2-entry tagged output stage.
module rr_grant_consumer
    import rr_grant_consumer_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 64,
    parameter  int DEPTH = 2,
    localparam int IDW   = clog2(N),
    localparam int CW    = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_an,
    input  logic [N-1:0]     s_valid,
    input  logic [N*W-1:0]   s_data,
    output logic [N-1:0]     s_ready,
    output logic [N-1:0]     req,
    output logic             arb_ena,
    input  logic [N-1:0]     grant,
    output logic             m_valid,
    output logic [W-1:0]     m_data,
    output logic [IDW-1:0]   m_id,
    input  logic             m_ready,
    output logic             err_grant
);

    logic [CW-1:0]    cnt  [N];
    logic [W-1:0]     head [N];
    logic [N-1:0]     nonempty;
    logic [N-1:0]     push;
    logic [N-1:0]     grant_ok;
    logic [1:0]       ocnt;
    logic [IDW+W-1:0] ohead;
    logic             g_onehot;
    logic             g_hit;
    logic             g_valid;
    logic             g_bad;
    logic             o_pop;
    logic             o_room;
    logic             req_en;
    logic [IDW-1:0]   gid;
    logic [W-1:0]     gdata;

    for (genvar i = 0; i < N; i++) begin : g_client
        assign s_ready[i]  = cnt[i] < CW'(DEPTH);
        assign nonempty[i] = cnt[i] != '0;
        assign push[i]     = s_valid[i] & s_ready[i];
        // A queue whose last entry is being granted drops req this cycle.
        assign req[i]      = req_en & ((cnt[i] - CW'(grant_ok[i])) != '0);

        sync_fifo #(
            .WIDTH (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_an(rst_an),
            .push  (push[i]),
            .wdata (s_data[i*W +: W]),
            .pop   (grant_ok[i]),
            .rdata (head[i]),
            .count (cnt[i])
        );
    end

    assign m_valid        = ocnt != 2'd0;
    assign {m_id, m_data} = ohead;

    always_comb begin
        g_onehot = onehot(32'(grant));
        g_hit    = |(grant & nonempty);
        o_pop    = m_valid & m_ready;
        o_room   = (ocnt != 2'd2) | o_pop;
        g_valid  = arb_ena & g_onehot & g_hit & o_room;
        g_bad    = arb_ena & (|grant) & ~(g_onehot & g_hit);
        grant_ok = g_valid ? grant : '0;
        req_en   = ({1'b0, ocnt} + {2'b00, |grant_ok}) < 3'd2;
        gid      = '0;
        gdata    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_ok[i]) begin
                gid   = IDW'(i);
                gdata = head[i];
            end
        end
    end

    sync_fifo #(
        .WIDTH (IDW + W),
        .DEPTH (2)
    ) u_out (
        .clk   (clk),
        .rst_an(rst_an),
        .push  (g_valid),
        .wdata ({gid, gdata}),
        .pop   (o_pop),
        .rdata (ohead),
        .count (ocnt)
    );

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            arb_ena   <= 1'b0;
            err_grant <= 1'b0;
        end else begin
            arb_ena <= 1'b1;
            if (g_bad) err_grant <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_grant_consumer.sv
// Bench for rr_grant_consumer: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_rr_grant_consumer;

    logic         clk;
    logic         rst_an;
    logic [3:0]   s_valid;
    logic [255:0] s_data;
    logic [3:0]   s_ready;
    logic [3:0]   req;
    logic         arb_ena;
    logic [3:0]   grant;
    logic         m_valid;
    logic [63:0]  m_data;
    logic [1:0]   m_id;
    logic         m_ready;
    logic         err_grant;

    int checks;
    int errors;

    rr_grant_consumer #(.N(4), .W(64), .DEPTH(2)) dut (
        .clk      (clk),
        .rst_an   (rst_an),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .req      (req),
        .arb_ena  (arb_ena),
        .grant    (grant),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_id     (m_id),
        .m_ready  (m_ready),
        .err_grant(err_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  id;
        logic [63:0] d;
    } oent_t;

    logic [63:0] mq [4][$];
    oent_t       oq [$];
    bit          merr;
    bit          mena;
    logic [3:0]  last_req;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] g);
        if ($countones(g) != 1) return -1;
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic bit m_gok(input logic [3:0] g, input logic mr);
        int idx;
        idx = oh_idx(g);
        if (!mena || idx < 0) return 0;
        return (mq[idx].size() > 0) && (oq.size() < 2 || mr);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
        oq.delete();
        merr = 0;
        mena = 0;
    endtask

    task automatic model_update(input logic [3:0] sv, input logic [255:0] sd,
                                input logic [3:0] g, input logic mr);
        int         idx;
        bit         gok;
        bit         bad;
        logic [3:0] sr;
        oent_t      e;
        idx = oh_idx(g);
        gok = m_gok(g, mr);
        bad = mena && (g != 0) && !(idx >= 0 && mq[idx].size() > 0);
        for (int i = 0; i < 4; i++) sr[i] = mq[i].size() < 2;
        if (oq.size() > 0 && mr) void'(oq.pop_front());
        if (gok) begin
            e.id = 2'(idx);
            e.d  = mq[idx].pop_front();
            oq.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            if (sv[i] && sr[i]) mq[i].push_back(sd[i*64 +: 64]);
        end
        if (bad) merr = 1;
        mena = 1;
    endtask

    task automatic check_model(input logic [3:0] g, input logic mr);
        int         idx;
        int         n;
        bit         gok;
        logic [3:0] er;
        logic [3:0] esr;
        idx = oh_idx(g);
        gok = m_gok(g, mr);
        for (int i = 0; i < 4; i++) begin
            esr[i] = mq[i].size() < 2;
            n = mq[i].size() - ((gok && idx == i) ? 1 : 0);
            er[i] = ((oq.size() + (gok ? 1 : 0)) < 2) && (n > 0);
        end
        chk("s_ready", 64'(s_ready), 64'(esr));
        chk("req", 64'(req), 64'(er));
        chk("m_valid", 64'(m_valid), 64'(oq.size() > 0));
        if (oq.size() > 0) begin
            chk("m_id", 64'(m_id), 64'(oq[0].id));
            chk("m_data", m_data, oq[0].d);
        end
        chk("err_grant", 64'(err_grant), 64'(merr));
        chk("arb_ena", 64'(arb_ena), 64'(mena));
        last_req = er;
    endtask

    // Called at posedge+1; leaves at next posedge+1.
    task automatic step(input logic [3:0] sv, input logic [255:0] sd,
                        input logic [3:0] g, input logic mr);
        s_valid = sv;
        s_data  = sd;
        grant   = g;
        m_ready = mr;
        @(negedge clk);
        check_model(g, mr);
        @(posedge clk);
        model_update(sv, sd, g, mr);
        #1;
    endtask

    task automatic do_reset();
        s_valid = '0;
        s_data  = '0;
        grant   = '0;
        m_ready = 1'b0;
        rst_an  = 1'b0;
        model_clear();
        @(posedge clk);
        #3;
        rst_an = 1'b1;
        chk("ena_before_edge", 64'(arb_ena), 64'd0);
        @(posedge clk);
        #1;
        mena = 1;
        chk("ena_after_edge", 64'(arb_ena), 64'd1);
    endtask

    function automatic logic [255:0] rnd_data();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic [3:0]  sv;
        logic [7:0]  d;
        logic [3:0]  g;
        logic        mr;
        logic [3:0]  req;
        logic        mv;
        logic [1:0]  id;
        logic [63:0] md;
        logic        err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [255:0] sd;
        logic [63:0]  seq;
        logic [63:0]  rx_next;
        logic [3:0]   g;
        int           r;
        int           k;
        checks = 0;
        errors = 0;

        vecs[0] = '{4'b0100, 8'hA5, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,  1'b0};
        vecs[1] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 64'h0,  1'b0};
        vecs[2] = '{4'b0000, 8'h00, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,  1'b0};
        vecs[3] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 64'hA5, 1'b0};
        vecs[4] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,  1'b0};
        vecs[5] = '{4'b0011, 8'h11, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h0,  1'b0};
        vecs[6] = '{4'b0000, 8'h00, 4'b0011, 1'b1, 4'b0011, 1'b0, 2'd0, 64'h0,  1'b0};
        vecs[7] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0011, 1'b0, 2'd0, 64'h0,  1'b1};
        vecs[8] = '{4'b0000, 8'h00, 4'b0001, 1'b1, 4'b0010, 1'b0, 2'd0, 64'h0,  1'b1};
        vecs[9] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0, 64'h11, 1'b1};

        // Reset state before any clock edge.
        rst_an  = 1'b0;
        s_valid = '0;
        s_data  = '0;
        grant   = '0;
        m_ready = 1'b0;
        #2;
        chk("rst_s_ready", 64'(s_ready), 64'hF);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_arb_ena", 64'(arb_ena), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_id", 64'(m_id), 64'd0);
        chk("rst_err", 64'(err_grant), 64'd0);
        @(posedge clk);
        #1;
        do_reset();

        // Basic grant path and illegal multi-hot grant.
        for (int i = 0; i < 10; i++) begin
            s_valid = vecs[i].sv;
            s_data  = {4{56'h0, vecs[i].d}};
            grant   = vecs[i].g;
            m_ready = vecs[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 64'(req), 64'(vecs[i].req));
            chk($sformatf("vec%0d_mv", i), 64'(m_valid), 64'(vecs[i].mv));
            if (vecs[i].mv) begin
                chk($sformatf("vec%0d_id", i), 64'(m_id), 64'(vecs[i].id));
                chk($sformatf("vec%0d_md", i), m_data, vecs[i].md);
            end
            chk($sformatf("vec%0d_err", i), 64'(err_grant), 64'(vecs[i].err));
            @(posedge clk);
            model_update(s_valid, s_data, grant, m_ready);
            #1;
        end

        // Grant to an empty client.
        do_reset();
        grant = 4'b1000;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        grant = 4'b0000;
        #2;
        chk("t5_err", 64'(err_grant), 64'd1);
        chk("t5_mv", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("t5_err_sticky", 64'(err_grant), 64'd1);
        chk("t5_mv2", 64'(m_valid), 64'd0);

        // Output stage full with m_ready low; grants beyond credit ignored.
        do_reset();
        step(4'hF, rnd_data(), 4'h0, 1'b0);
        step(4'hF, rnd_data(), 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(4'h0, '0, 4'(1 << (i % 4)), 1'b0);
        s_valid = '0;
        grant   = '0;
        #2;
        chk("t2_s_ready", 64'(s_ready), 64'b0011);
        chk("t2_req", 64'(req), 64'd0);
        chk("t2_head_id", 64'(m_id), 64'd0);
        step(4'h0, '0, 4'h0, 1'b1);
        #2;
        chk("t2_second_id", 64'(m_id), 64'd1);
        for (int i = 0; i < 4; i++) step(4'h0, '0, 4'h0, 1'b1);
        chk("t2_drained", 64'(m_valid), 64'd0);

        // Client 0 filled, then push and grant-pop every cycle.
        do_reset();
        seq = 64'd0;
        rx_next = 64'd0;
        for (int i = 0; i < 2; i++) begin
            step(4'b0001, {192'h0, seq}, 4'h0, 1'b1);
            seq++;
        end
        chk("t3_full", 64'(s_ready[0]), 64'd0);
        for (int i = 0; i < 12; i++) begin
            if (m_valid && m_id == 2'd0) begin
                chk("t3_order", m_data, rx_next);
                rx_next++;
            end
            k = (mq[0].size() < 2) ? 1 : 0;
            step(4'b0001, {192'h0, seq}, 4'b0001, 1'b1);
            if (k == 1) seq++;
        end
        chk("t3_count_ge8", 64'(rx_next >= 8), 64'd1);

        // Asynchronous reset with data in flight.
        do_reset();
        step(4'hF, rnd_data(), 4'h0, 1'b0);
        step(4'b0011, rnd_data(), 4'b0001, 1'b0);
        step(4'b0011, rnd_data(), 4'b0010, 1'b0);
        chk("t6_full_out", 64'(m_valid), 64'd1);
        #2;
        rst_an = 1'b0;
        #1;
        chk("t6_mv", 64'(m_valid), 64'd0);
        chk("t6_req", 64'(req), 64'd0);
        chk("t6_s_ready", 64'(s_ready), 64'hF);
        chk("t6_m_data", m_data, 64'd0);
        chk("t6_ena", 64'(arb_ena), 64'd0);
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) step(4'h0, '0, 4'h0, 1'b1);

        // Randomized traffic with arbiter-like and rogue grants.
        do_reset();
        last_req = '0;
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            g = '0;
            if (r < 55) begin
                if (last_req != 0) begin
                    do k = $urandom_range(0, 3); while (!last_req[k]);
                    g = 4'(1 << k);
                end
            end else if (r < 75) begin
                g = 4'(1 << $urandom_range(0, 3));
            end else if (r == 99) begin
                g = 4'($urandom_range(0, 15));
            end
            sd = rnd_data();
            step(4'($urandom_range(0, 15)), sd, g, ($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
